// File: rtl/calc_num_pkg.sv
// calc_num_pkg: shared number-format types, default widths and helpers for the calculator datapath.
package calc_num_pkg;
   typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_ROUND, S_CHECK, S_DONE} state_t;
   localparam int MANT_W_DEF = 34;
   localparam int EXP_W_DEF = 7;
   function automatic logic [127:0] m_max(input int width);
      return (128'(1) << width) - 128'(1);
   endfunction
endpackage

// File: rtl/dec_float_multiplier_div10_step.sv
// div10_step: combinational single-step divide by ten, returning quotient and last decimal digit.
module div10_step #(
   parameter int W = 68
) (
   input  logic [W-1:0] num_i,
   output logic [W-1:0] quo_o,
   output logic [3:0]   rem_o
);
   localparam logic [W-1:0] TEN = W'(10);
   logic [W-1:0] mod;
   assign quo_o = num_i / TEN;
   assign mod = num_i % TEN;
   assign rem_o = mod[3:0];
endmodule

// File: rtl/dec_float_multiplier.sv
// dec_float_multiplier: multi-cycle decimal floating-point multiplier (mant * 10^exp).
// Rounding half-up on the last dropped digit is enabled with DEC_MUL_ROUND_EN.
module dec_float_multiplier
   import calc_num_pkg::*;
#(
   parameter int MANT_W = MANT_W_DEF,
   parameter int EXP_W = EXP_W_DEF
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     eval,
   input  logic                     signA,
   input  logic                     signB,
   input  logic [MANT_W-1:0]        mantA,
   input  logic [MANT_W-1:0]        mantB,
   input  logic signed [EXP_W-1:0]  expA,
   input  logic signed [EXP_W-1:0]  expB,
   output logic                     busy,
   output logic                     done,
   output logic                     signRes,
   output logic [MANT_W-1:0]        mantRes,
   output logic signed [EXP_W-1:0]  expRes,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int PW = 2 * MANT_W;
   localparam int IW = EXP_W + $clog2(MANT_W) + 1;
   localparam logic [PW-1:0] M_MAX = PW'(m_max(MANT_W));
   localparam logic signed [IW-1:0] E_MAX = IW'(2 ** (EXP_W - 1) - 1);
   localparam logic signed [IW-1:0] E_MIN = IW'(-(2 ** (EXP_W - 1)));
   localparam logic signed [IW-1:0] E_ONE = IW'(1);

   state_t                   state_q, state_d;
   logic                     eval_prev_q, eval_prev_d;
   logic                     sa_q, sa_d, sb_q, sb_d;
   logic [MANT_W-1:0]        ma_q, ma_d, mb_q, mb_d;
   logic signed [EXP_W-1:0]  ea_q, ea_d, eb_q, eb_d;
   logic                     sign_q, sign_d;
   logic [PW-1:0]            prod_q, prod_d;
   logic signed [IW-1:0]     exp_q, exp_d;
   logic [3:0]               rem_q, rem_d;
   logic                     busy_q, busy_d, done_q, done_d;
   logic                     sres_q, sres_d, ovf_q, ovf_d, unf_q, unf_d;
   logic [MANT_W-1:0]        mres_q, mres_d;
   logic signed [EXP_W-1:0]  eres_q, eres_d;
   logic [PW-1:0]            quo;
   logic [3:0]               rem;
   logic [PW-1:0]            mul;

   div10_step #(.W(PW)) u_div (.num_i(prod_q), .quo_o(quo), .rem_o(rem));

   assign mul = {{MANT_W{1'b0}}, ma_q} * {{MANT_W{1'b0}}, mb_q};

   always_comb begin
      state_d = state_q;
      eval_prev_d = eval;
      sa_d = sa_q;
      sb_d = sb_q;
      ma_d = ma_q;
      mb_d = mb_q;
      ea_d = ea_q;
      eb_d = eb_q;
      sign_d = sign_q;
      prod_d = prod_q;
      exp_d = exp_q;
      rem_d = rem_q;
      busy_d = busy_q;
      done_d = 1'b0;
      sres_d = sres_q;
      mres_d = mres_q;
      eres_d = eres_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      case (state_q)
         S_IDLE: if (eval && !eval_prev_q) begin
            {sa_d, sb_d, ma_d, mb_d, ea_d, eb_d} = {signA, signB, mantA, mantB, expA, expB};
            {ovf_d, unf_d} = 2'b00;
            busy_d = 1'b1;
            state_d = S_MUL;
         end
         S_MUL: begin
            prod_d = mul;
            rem_d = 4'd0;
            // zero is canonical: positive, exponent 0, so it can never raise a flag
            sign_d = (mul == '0) ? 1'b0 : sa_q ^ sb_q;
            exp_d = (mul == '0) ? '0 : IW'(ea_q) + IW'(eb_q);
            state_d = S_NORM;
         end
         S_NORM: if (prod_q > M_MAX) begin
            prod_d = quo;
            rem_d = rem;
            exp_d = exp_q + E_ONE;
         end else begin
            state_d = S_ROUND;
         end
         S_ROUND: begin
`ifdef DEC_MUL_ROUND_EN
            prod_d = prod_q + PW'(rem_q >= 4'd5);
`endif
            state_d = (prod_d > M_MAX) ? S_NORM : S_CHECK;
         end
         S_CHECK: begin
            sres_d = (exp_q < E_MIN) ? 1'b0 : sign_q;
            mres_d = (exp_q > E_MAX) ? M_MAX[MANT_W-1:0] : (exp_q < E_MIN) ? '0 : prod_q[MANT_W-1:0];
            eres_d = (exp_q > E_MAX) ? E_MAX[EXP_W-1:0] : (exp_q < E_MIN) ? '0 : exp_q[EXP_W-1:0];
            ovf_d = exp_q > E_MAX;
            unf_d = exp_q < E_MIN;
            state_d = S_DONE;
         end
         S_DONE: begin
            done_d = 1'b1;
            busy_d = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         eval_prev_q <= 1'b0;
         {sa_q, sb_q, ma_q, mb_q, ea_q, eb_q} <= '0;
         sign_q <= 1'b0;
         prod_q <= '0;
         exp_q <= '0;
         rem_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         sres_q <= 1'b0;
         mres_q <= '0;
         eres_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         eval_prev_q <= eval_prev_d;
         {sa_q, sb_q, ma_q, mb_q, ea_q, eb_q} <= {sa_d, sb_d, ma_d, mb_d, ea_d, eb_d};
         sign_q <= sign_d;
         prod_q <= prod_d;
         exp_q <= exp_d;
         rem_q <= rem_d;
         busy_q <= busy_d;
         done_q <= done_d;
         sres_q <= sres_d;
         mres_q <= mres_d;
         eres_q <= eres_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign signRes = sres_q;
   assign mantRes = mres_q;
   assign expRes = eres_q;
   assign overflow = ovf_q;
   assign underflow = unf_q;
endmodule
